// File: rtl/shared_bus_initiator_if.sv
// shared_bus_initiator_if: controller request/completion handshake plus shared-bus and snoop signals.
interface shared_bus_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_data;
    logic [LINE_W-1:0] sharedBus;
    logic [7:0]        sharedOperationBus;
    logic [1:0]        snoopBus;
    logic              done_valid;
    logic [1:0]        done_result;
    logic              done_error;

    modport master (
        input  req_valid, req_op, req_addr, req_data, snoopBus,
        output req_ready, sharedBus, sharedOperationBus, done_valid, done_result, done_error
    );

    modport slave (
        output req_valid, req_op, req_addr, req_data, snoopBus,
        input  req_ready, sharedBus, sharedOperationBus, done_valid, done_result, done_error
    );
endinterface

// File: rtl/shared_bus_initiator.sv
// shared_bus_initiator: issues one L2 transaction on the shared bus, retries on HITM, reports the snoop result.
// Defining SHARED_BUS_TRACE_EN prints a trace line on every completion.
module shared_bus_initiator #(
    parameter int ADDR_W        = 32,
    parameter int LINE_W        = 512,
    parameter int SNOOP_TIMEOUT = 15,
    parameter int MAX_RETRY     = 3
) (
    input logic clock,
    input logic reset,
    shared_bus_initiator_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int WW = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    localparam logic [WW-1:0] TMAX = WW'(SNOOP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, SNOOP, BACKOFF, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [WW-1:0]     wait_q, wait_d, wait_inc;
    logic [1:0]        result_d;
    logic              err_d;
    logic              ready_q, dv_q, err_q;
    logic [1:0]        res_q;
    logic [7:0]        opbus_q;
    logic [LINE_W-1:0] bus_q;

    assign wait_inc = (wait_q == TMAX) ? wait_q : wait_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        retry_d  = retry_q;
        wait_d   = wait_q;
        result_d = 2'b10;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                op_d    = bus.req_op;
                addr_d  = bus.req_addr;
                data_d  = bus.req_data;
                retry_d = '0;
                wait_d  = '0;
                err_d   = !(bus.req_op inside {"R", "M", "I", "W"});
                state_d = err_d ? DONE : ADDR;
            end
            ADDR: begin
                state_d = (op_q == "W") ? DATA : SNOOP;
                wait_d  = '0;
            end
            DATA: state_d = DONE;
            SNOOP: case (bus.snoopBus)
                2'b00, 2'b10: begin
                    state_d  = DONE;
                    result_d = bus.snoopBus;
                end
                2'b01: if (retry_q < RMAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = BACKOFF;
                end else begin
                    state_d  = DONE;
                    result_d = 2'b01;
                    err_d    = 1'b1;
                end
                default: begin
                    wait_d = wait_inc;
                    if (wait_inc == TMAX) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            endcase
            // the owner signals the end of its writeback by going quiet
            BACKOFF: if (bus.snoopBus == 2'b11) begin
                state_d = ADDR;
                wait_d  = '0;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from next-state so each phase is visible the cycle after its transition
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            retry_q <= '0;
            wait_q  <= '0;
            ready_q <= 1'b1;
            dv_q    <= 1'b0;
            res_q   <= 2'b10;
            err_q   <= 1'b0;
            opbus_q <= '0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            wait_q  <= wait_d;
            ready_q <= state_d == IDLE;
            dv_q    <= state_d == DONE;
            err_q   <= (state_d == DONE) && err_d;
            if (state_d == DONE)
                res_q <= result_d;
            opbus_q <= (state_d == ADDR || state_d == DATA) ? op_d : 8'h00;
            bus_q   <= (state_d == ADDR) ? {{(LINE_W-ADDR_W){1'b0}}, addr_d} :
                       (state_d == DATA) ? data_d : '0;
        end
    end

    assign bus.req_ready          = ready_q;
    assign bus.done_valid         = dv_q;
    assign bus.done_result        = res_q;
    assign bus.done_error         = err_q;
    assign bus.sharedOperationBus = opbus_q;
    assign bus.sharedBus          = bus_q;

`ifdef SHARED_BUS_TRACE_EN
    always_ff @(posedge clock) begin
        if (dv_q)
            $display("[shared_bus] op=%c addr=%8h result=%b error=%b retries=%0d", op_q, addr_q, res_q, err_q, retry_q);
    end
`else
`endif
endmodule
